rtermcal_ctrl: RTL and testbench

// - Digital controller for the RTERMCAL termination-calibration cell. Drives the trim codes and MODE

---
 rtl/rtermcal_pkg.sv | 32 +++
 rtl/rtermcal_sync.sv | 26 ++
 rtl/rtermcal_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rtermcal_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtermcal_pkg.sv
// Shared types and helpers for the RTERMCAL calibration controller.
// State encoding, mode values and the thermometer encoder.
package rtermcal_pkg;

   localparam int SGIO_ELEMS = 15;
   localparam int LVDS_BITS  = 4;

   localparam logic [1:0] MODE_OFF = 2'b00;
   localparam logic [1:0] MODE_SG  = 2'b01;
   localparam logic [1:0] MODE_LV  = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      SG_SET,
      SG_WAIT,
      SG_EVAL,
      LV_SET,
      LV_WAIT,
      LV_EVAL,
      DONE
   } state_t;

   function automatic logic [SGIO_ELEMS-1:0] bin2therm(input logic [3:0] n);
      logic [SGIO_ELEMS-1:0] t;
      t = '0;
      for (int i = 0; i < SGIO_ELEMS; i++) begin
         t[i] = (i < int'(n));
      end
      return t;
   endfunction

endpackage

// File: rtl/rtermcal_sync.sv
// Reset-clearing multi-stage synchronizer for the comparator result.
// The comparator output is asynchronous to the controller clock.
module rtermcal_sync #(
   parameter int STAGES = 2,
   parameter int W      = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [STAGES-1:0][W-1:0] ff;

   // shift the asynchronous input through the flop chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/rtermcal_ctrl.sv
// Termination-calibration controller: SGIO linear thermometer sweep
// followed by a 4-bit LVDS successive-approximation search.
module rtermcal_ctrl
   import rtermcal_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                  CLK_I,
   input  logic                  RST_NI,
   input  logic                  START_I,
   input  logic [1:0]            RESULT_I,
   output logic [1:0]            MODE_O,
   output logic [SGIO_ELEMS-1:0] D_IOSG_O,
   output logic [LVDS_BITS-1:0]  D_LVDS_O,
   output logic [3:0]            SGIO_CODE_O,
   output logic                  BUSY_O,
   output logic                  DONE_O,
   output logic [1:0]            ERR_O
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0] sg_q, sg_d;
   logic [SGIO_ELEMS-1:0] therm_q, therm_d;
   logic [LVDS_BITS-1:0] lv_q, lv_d, lv_v;
   logic [1:0] bit_q, bit_d;
   logic [1:0] mode_q, mode_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic [1:0] err_q, err_d;
   logic [1:0] res;

   rtermcal_sync #(
      .STAGES (SYNC_STAGES),
      .W      (2)
   ) u_sync (
      .clk   (CLK_I),
      .rst_n (RST_NI),
      .d     (RESULT_I),
      .q     (res)
   );

   // state and all output registers
   always_ff @(posedge CLK_I or negedge RST_NI) begin
      if (!RST_NI) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sg_q    <= '0;
         therm_q <= '0;
         lv_q    <= '0;
         bit_q   <= '0;
         mode_q  <= MODE_OFF;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sg_q    <= sg_d;
         therm_q <= therm_d;
         lv_q    <= lv_d;
         bit_q   <= bit_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // next-state and next-output logic for both searches
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sg_d    = sg_q;
      lv_d    = lv_q;
      lv_v    = lv_q;
      bit_d   = bit_q;
      mode_d  = mode_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (START_I) begin
               state_d = SG_SET;
               busy_d  = 1'b1;
               err_d   = '0;
               sg_d    = '0;
               lv_d    = '0;
               mode_d  = MODE_SG;
            end
         end
         SG_SET: begin
            cnt_d   = '0;
            state_d = SG_WAIT;
         end
         SG_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = SG_EVAL;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SG_EVAL: begin
            if (!res[0] && sg_q != 4'(SGIO_ELEMS)) begin
               sg_d    = sg_q + 4'd1;
               state_d = SG_SET;
            end else begin
               // limit hit at either end keeps the current code
               if (res[0] && sg_q != 4'd0) begin
                  sg_d = sg_q - 4'd1;
               end else begin
                  err_d[0] = 1'b1;
               end
               state_d = LV_SET;
               mode_d  = MODE_LV;
               lv_d    = 4'b1000;
               bit_d   = 2'd3;
            end
         end
         LV_SET: begin
            cnt_d   = '0;
            state_d = LV_WAIT;
         end
         LV_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = LV_EVAL;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LV_EVAL: begin
            if (res[1]) begin
               lv_v[bit_q] = 1'b0;
            end
            lv_d = lv_v;
            if (bit_q == 2'd0) begin
               state_d  = DONE;
               mode_d   = MODE_OFF;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               err_d[1] = (lv_v == 4'd0 && res[1]) || (lv_v == 4'hF);
            end else begin
               bit_d             = bit_q - 2'd1;
               lv_d[bit_q-2'd1] = 1'b1;
               state_d           = LV_SET;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      therm_d = bin2therm(sg_d);
   end

   assign MODE_O      = mode_q;
   assign D_IOSG_O    = therm_q;
   assign D_LVDS_O    = lv_q;
   assign SGIO_CODE_O = sg_q;
   assign BUSY_O      = busy_q;
   assign DONE_O      = done_q;
   assign ERR_O       = err_q;

endmodule

// File: tb/tb_rtermcal_ctrl.sv
// Directed bench for rtermcal_ctrl with a behavioural comparator model.
// Table of calibration scenarios plus reset, busy-START and idle sequences.
module tb_rtermcal_ctrl;

   localparam int S   = 16;
   localparam int DLY = S - 1;
   localparam int WORST = 20 * (S + 2) + 2;

   logic        CLK_I;
   logic        RST_NI;
   logic        START_I;
   logic [1:0]  RESULT_I;
   logic [1:0]  MODE_O;
   logic [14:0] D_IOSG_O;
   logic [3:0]  D_LVDS_O;
   logic [3:0]  SGIO_CODE_O;
   logic        BUSY_O;
   logic        DONE_O;
   logic [1:0]  ERR_O;

   int total;
   int bad;
   int done_cnt;
   int mode_bad;

   bit         force_en;
   logic [1:0] force_val;
   logic [1:0] raw;
   logic [1:0] dl [DLY];

   typedef struct {
      bit          fen;
      logic [1:0]  fval;
      logic [3:0]  sg;
      logic [14:0] th;
      logic [3:0]  lv;
      logic [1:0]  err;
      int          trials;
   } vec_t;

   vec_t vt [3];

   rtermcal_ctrl #(
      .SETTLE_CYCLES (S),
      .SYNC_STAGES   (2)
   ) dut (
      .CLK_I       (CLK_I),
      .RST_NI      (RST_NI),
      .START_I     (START_I),
      .RESULT_I    (RESULT_I),
      .MODE_O      (MODE_O),
      .D_IOSG_O    (D_IOSG_O),
      .D_LVDS_O    (D_LVDS_O),
      .SGIO_CODE_O (SGIO_CODE_O),
      .BUSY_O      (BUSY_O),
      .DONE_O      (DONE_O),
      .ERR_O       (ERR_O)
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   // comparator model: resistance falls as the code rises
   always_comb begin
      raw = 2'b00;
      if (force_en) begin
         raw = force_val;
      end else begin
         raw[0] = (MODE_O == 2'b01) &&
                  ((20 + 5000 / (17 + int'(SGIO_CODE_O))) < 200);
         raw[1] = (MODE_O == 2'b10) &&
                  ((-10 + 5000 / (17 + int'(D_LVDS_O))) < 200);
      end
   end

   // analog settling delay of the cell
   always @(posedge CLK_I) begin
      dl[0] <= raw;
      for (int i = 1; i < DLY; i++) dl[i] <= dl[i-1];
   end

   assign RESULT_I = dl[DLY-1];

   always @(negedge CLK_I) begin
      if (DONE_O) done_cnt++;
      if (MODE_O == 2'b11) mode_bad++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK_I);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mode"}, 32'(MODE_O), 32'd0);
      chk({tag, "_iosg"}, 32'(D_IOSG_O), 32'd0);
      chk({tag, "_lvds"}, 32'(D_LVDS_O), 32'd0);
      chk({tag, "_sg"}, 32'(SGIO_CODE_O), 32'd0);
      chk({tag, "_busy"}, 32'(BUSY_O), 32'd0);
      chk({tag, "_done"}, 32'(DONE_O), 32'd0);
      chk({tag, "_err"}, 32'(ERR_O), 32'd0);
   endtask

   // one calibration; optional START pulse in the middle of it
   task automatic run_cal(input vec_t v, input bit poke, input string tag);
      int lat;
      bit seen;
      force_en  = v.fen;
      force_val = v.fval;
      idle(40);
      @(negedge CLK_I);
      START_I = 1'b1;
      @(negedge CLK_I);
      START_I = 1'b0;
      chk({tag, "_busy_start"}, 32'(BUSY_O), 32'd1);
      chk({tag, "_mode_start"}, 32'(MODE_O), 32'd1);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < WORST + 20) begin
         @(negedge CLK_I);
         lat++;
         if (poke && lat == 100) START_I = 1'b1;
         if (poke && lat == 101) START_I = 1'b0;
         if (DONE_O) seen = 1'b1;
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_latency"}, 32'(lat), 32'(v.trials * (S + 2)));
      chk({tag, "_lat_bound"}, 32'(lat <= WORST), 32'd1);
      chk({tag, "_busy_end"}, 32'(BUSY_O), 32'd0);
      chk({tag, "_mode_end"}, 32'(MODE_O), 32'd0);
      chk({tag, "_sg"}, 32'(SGIO_CODE_O), 32'(v.sg));
      chk({tag, "_iosg"}, 32'(D_IOSG_O), 32'(v.th));
      chk({tag, "_lvds"}, 32'(D_LVDS_O), 32'(v.lv));
      chk({tag, "_err"}, 32'(ERR_O), 32'(v.err));
      @(negedge CLK_I);
      chk({tag, "_done_pulse"}, 32'(DONE_O), 32'd0);
   endtask

   initial begin
      int d0;
      int w;
      total     = 0;
      bad       = 0;
      done_cnt  = 0;
      mode_bad  = 0;
      force_en  = 1'b0;
      force_val = 2'b00;
      START_I   = 1'b0;
      RST_NI    = 1'b0;

      vt[0] = '{fen: 1'b0, fval: 2'b00, sg: 4'd10, th: 15'h03FF,
                lv: 4'd6, err: 2'b00, trials: 16};
      vt[1] = '{fen: 1'b1, fval: 2'b11, sg: 4'd0, th: 15'h0000,
                lv: 4'd0, err: 2'b11, trials: 5};
      vt[2] = '{fen: 1'b1, fval: 2'b00, sg: 4'd15, th: 15'h7FFF,
                lv: 4'd15, err: 2'b11, trials: 20};

      idle(4);
      chk_reset_vals("rst");
      RST_NI = 1'b1;
      idle(4);

      for (int k = 0; k < 3; k++) begin
         run_cal(vt[k], 1'b0, $sformatf("vec%0d", k));
      end

      // reset while the LVDS search is settling
      force_en = 1'b0;
      idle(40);
      @(negedge CLK_I);
      START_I = 1'b1;
      @(negedge CLK_I);
      START_I = 1'b0;
      d0 = done_cnt;
      w  = 0;
      while (MODE_O != 2'b10 && w < WORST) begin
         @(negedge CLK_I);
         w++;
      end
      chk("lv_reached", 32'(MODE_O), 32'd2);
      @(negedge CLK_I);
      RST_NI = 1'b0;
      #1;
      chk_reset_vals("abort");
      @(negedge CLK_I);
      chk_reset_vals("abort_edge");
      RST_NI = 1'b1;
      idle(30);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_cal(vt[0], 1'b0, "post_rst");

      // START pulse while busy is ignored
      d0 = done_cnt;
      run_cal(vt[0], 1'b1, "busy_start");
      idle(40);
      chk("busy_one_done", 32'(done_cnt - d0), 32'd1);
      chk("busy_idle", 32'(BUSY_O), 32'd0);

      // comparator activity while MODE_O is off has no effect
      d0        = done_cnt;
      force_en  = 1'b1;
      force_val = 2'b11;
      idle(40);
      chk("off_sg", 32'(SGIO_CODE_O), 32'd10);
      chk("off_lvds", 32'(D_LVDS_O), 32'd6);
      chk("off_busy", 32'(BUSY_O), 32'd0);
      chk("off_done", 32'(done_cnt - d0), 32'd0);
      chk("mode_never_11", 32'(mode_bad), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
